// File: rtl/fetch_prefetch_unit_pkg.sv
// Shared fetch definitions: default geometry, NOP encoding, queue entry
// sizing helpers and the queue operation encoding used by fetch_queue.
package fetch_prefetch_unit_pkg;

    localparam int unsigned DEFAULT_PC_WIDTH     = 20;
    localparam int unsigned DEFAULT_INSTR_WIDTH  = 32;
    localparam int unsigned DEFAULT_PC_INCREMENT = 4;
    localparam int unsigned DEFAULT_FETCH_DEPTH  = 4;

    // Canonical no-op (addi x0, x0, 0) for stages that need a bubble filler.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // What the prefetch queue does on a given cycle.
    typedef enum logic [1:0] {
        Q_IDLE     = 2'b00,
        Q_PUSH     = 2'b01,
        Q_POP      = 2'b10,
        Q_PUSH_POP = 2'b11
    } queue_op_e;

    // A queue entry is the instruction word with its PC packed above it.
    function automatic int unsigned entry_width(input int unsigned pcw,
                                                input int unsigned iw);
        return pcw + iw;
    endfunction

    // Counters must hold the value "depth" itself, not just depth-1.
    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_prefetch_unit_if.sv
// Bundles the instruction SRAM handshake and the IF/ID valid/ready port.
// The fetch unit is the master; memory plus decode form the slave side.
interface fetch_prefetch_unit_if
    import fetch_prefetch_unit_pkg::*;
#(
    parameter int unsigned PC_DATA_WIDTH     = DEFAULT_PC_WIDTH,
    parameter int unsigned INSTRUCTION_WIDTH = DEFAULT_INSTR_WIDTH
);

    logic                         mem_req_out;
    logic [PC_DATA_WIDTH-1:0]     mem_addr_out;
    logic                         mem_gnt_in;
    logic                         mem_rvalid_in;
    logic [INSTRUCTION_WIDTH-1:0] mem_rdata_in;

    logic                         if_valid_out;
    logic                         if_ready_in;
    logic [PC_DATA_WIDTH-1:0]     if_pc_out;
    logic [PC_DATA_WIDTH-1:0]     if_next_pc_out;
    logic [INSTRUCTION_WIDTH-1:0] if_instr_out;

    modport master (
        output mem_req_out,
        output mem_addr_out,
        input  mem_gnt_in,
        input  mem_rvalid_in,
        input  mem_rdata_in,
        output if_valid_out,
        input  if_ready_in,
        output if_pc_out,
        output if_next_pc_out,
        output if_instr_out
    );

    modport slave (
        input  mem_req_out,
        input  mem_addr_out,
        output mem_gnt_in,
        output mem_rvalid_in,
        output mem_rdata_in,
        input  if_valid_out,
        output if_ready_in,
        input  if_pc_out,
        input  if_next_pc_out,
        input  if_instr_out
    );

endinterface

// File: rtl/fetch_prefetch_unit_fetch_queue.sv
// Synchronous FIFO holding fetched {pc, instr} entries. Flush empties it in
// one cycle; push and pop may happen together, including when full.
module fetch_queue
    import fetch_prefetch_unit_pkg::*;
#(
    parameter int unsigned WIDTH = entry_width(DEFAULT_PC_WIDTH, DEFAULT_INSTR_WIDTH),
    parameter int unsigned DEPTH = DEFAULT_FETCH_DEPTH,
    parameter int unsigned CW    = count_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;
    queue_op_e        op;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(DEPTH));
    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];

    // Next pointer/count values; a full queue only accepts a push alongside a pop.
    always_comb begin
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        op       = queue_op_e'({do_pop, do_push});
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        case (op)
            Q_PUSH: begin
                wr_ptr_d = wr_ptr_q + AW'(1);
                count_d  = count_q + CW'(1);
            end
            Q_POP: begin
                rd_ptr_d = rd_ptr_q + AW'(1);
                count_d  = count_q - CW'(1);
            end
            Q_PUSH_POP: begin
                wr_ptr_d = wr_ptr_q + AW'(1);
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            default: ;
        endcase
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only observed while count is non-zero.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch stage: issues sequential PCs to instruction SRAM, tags
// in-order responses with their PC, buffers them in a prefetch queue and
// hands them to IF/ID. A redirect restarts fetch and discards everything
// still in flight at that moment.
module fetch_prefetch_unit
    import fetch_prefetch_unit_pkg::*;
#(
    parameter int unsigned              PC_DATA_WIDTH      = DEFAULT_PC_WIDTH,
    parameter int unsigned              INSTRUCTION_WIDTH  = DEFAULT_INSTR_WIDTH,
    parameter logic [PC_DATA_WIDTH-1:0] PC_INITIAL_ADDRESS = '0,
    parameter int unsigned              PC_INCREMENT       = DEFAULT_PC_INCREMENT,
    parameter int unsigned              FETCH_DEPTH        = DEFAULT_FETCH_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     fetch_en_in,
    input  logic                     redirect_in,
    input  logic [PC_DATA_WIDTH-1:0] redirect_pc_in,
    fetch_prefetch_unit_if.master    bus
);

    localparam int unsigned PCW = PC_DATA_WIDTH;
    localparam int unsigned IW  = INSTRUCTION_WIDTH;
    localparam int unsigned EW  = entry_width(PCW, IW);
    localparam int unsigned CW  = count_width(FETCH_DEPTH);

    localparam logic [PCW-1:0] PC_STEP     = PCW'(PC_INCREMENT);
    localparam logic [CW:0]    DEPTH_LIMIT = (CW + 1)'(FETCH_DEPTH);

    logic [PCW-1:0] pc_q, pc_d;
    logic [PCW-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]  out_q, out_d;
    logic [CW-1:0]  disc_q, disc_d;

    logic           req;
    logic           issue;
    logic           rsp_ok;
    logic           q_push;
    logic           q_pop;
    logic           q_flush;
    logic [CW:0]    credit_sum;
    logic [EW-1:0]  q_push_data;
    logic [EW-1:0]  q_head;
    logic           q_full;
    logic           q_empty;
    logic [CW-1:0]  q_count;
    logic [PCW-1:0] head_pc;
    logic [IW-1:0]  head_instr;

    // Request/credit handshake: queued plus in-flight words never exceed the
    // queue depth, so every accepted response is guaranteed a free slot.
    always_comb begin
        credit_sum  = {1'b0, q_count} + {1'b0, out_q};
        req         = rst_n & fetch_en_in & ~redirect_in & (credit_sum < DEPTH_LIMIT);
        issue       = req & bus.mem_gnt_in;
        rsp_ok      = bus.mem_rvalid_in & (out_q != '0);
        q_push      = rsp_ok & (disc_q == '0) & ~redirect_in;
        q_pop       = ~q_empty & bus.if_ready_in & ~redirect_in;
        q_flush     = redirect_in;
        q_push_data = {resp_pc_q, bus.mem_rdata_in};
    end

    // Next-state for PCs and the outstanding/discard counters; a redirect
    // marks every request still in flight after this edge as stale.
    always_comb begin
        pc_d      = pc_q;
        resp_pc_d = resp_pc_q;
        out_d     = out_q + CW'(issue) - CW'(rsp_ok);
        disc_d    = disc_q;
        if (redirect_in) begin
            pc_d      = redirect_pc_in;
            resp_pc_d = redirect_pc_in;
            disc_d    = out_d;
        end else begin
            if (issue) begin
                pc_d = pc_q + PC_STEP;
            end
            if (q_push) begin
                resp_pc_d = resp_pc_q + PC_STEP;
            end
            if (rsp_ok && (disc_q != '0)) begin
                disc_d = disc_q - CW'(1);
            end
        end
    end

    // Fetch state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= PC_INITIAL_ADDRESS;
            resp_pc_q <= PC_INITIAL_ADDRESS;
            out_q     <= '0;
            disc_q    <= '0;
        end else begin
            pc_q      <= pc_d;
            resp_pc_q <= resp_pc_d;
            out_q     <= out_d;
            disc_q    <= disc_d;
        end
    end

    fetch_queue #(
        .WIDTH (EW),
        .DEPTH (FETCH_DEPTH),
        .CW    (CW)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (q_push),
        .push_data (q_push_data),
        .pop       (q_pop),
        .flush     (q_flush),
        .head_data (q_head),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count)
    );

    assign head_pc    = q_head[EW-1 -: PCW];
    assign head_instr = q_head[IW-1:0];

    assign bus.mem_req_out    = req;
    assign bus.mem_addr_out   = pc_q;
    assign bus.if_valid_out   = ~q_empty;
    assign bus.if_pc_out      = q_empty ? '0 : head_pc;
    assign bus.if_next_pc_out = q_empty ? '0 : (head_pc + PC_STEP);
    assign bus.if_instr_out   = q_empty ? '0 : head_instr;

    // A response with nothing outstanding indicates a broken memory model.
    a_no_orphan_response : assert property (
        @(posedge clk) disable iff (!rst_n) bus.mem_rvalid_in |-> (out_q != '0)
    );

    // The credit rule must keep pushes from ever landing on a full queue.
    a_no_overflow : assert property (
        @(posedge clk) disable iff (!rst_n) q_push |-> (!q_full || q_pop)
    );

endmodule
